// File: rtl/dm_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// stbuf_pkg: shared types and default sizes for the dm_store_buffer slice.
//   stbuf_entry_t : one buffered store {word address, data}.
//   STBUF_N       : default data width.
//   STBUF_DEPTH   : default number of store entries (power of two, >= 2).
//   STBUF_AW      : default memory word-address width.
// The entry struct is sized by STBUF_N / STBUF_AW, so a top-level N/AW
// override must be matched here.
// -----------------------------------------------------------------------------
package stbuf_pkg;

  localparam int unsigned STBUF_N     = 64;
  localparam int unsigned STBUF_DEPTH = 4;
  localparam int unsigned STBUF_AW    = 6;

  typedef struct packed {
    logic [STBUF_AW-1:0] waddr;
    logic [STBUF_N-1:0]  data;
  } stbuf_entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// -----------------------------------------------------------------------------
// dm_store_buffer_if: CPU-side and memory-side signals of the store buffer.
//   CPU side : cpu_addr, cpu_wdata, cpu_we, cpu_re -> buffer; cpu_rdata, stall <-
//   Mem side : mem_ready, mem_rdata -> buffer; mem_we, mem_re, mem_addr,
//              mem_wdata <-
//   Misc     : dump_req -> buffer; mem_dump, empty, count <-
// Modports: slave = store buffer view, master = CPU/memory/bench view.
// -----------------------------------------------------------------------------
interface dm_store_buffer_if
  import stbuf_pkg::*;
#(
  parameter int unsigned N     = STBUF_N,
  parameter int unsigned DEPTH = STBUF_DEPTH,
  parameter int unsigned AW    = STBUF_AW
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [N-1:0]  cpu_addr;
  logic [N-1:0]  cpu_wdata;
  logic          cpu_we;
  logic          cpu_re;
  logic [N-1:0]  cpu_rdata;
  logic          stall;
  logic          mem_ready;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
  logic          dump_req;
  logic          mem_dump;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ready, mem_rdata, dump_req,
    output cpu_rdata, stall, mem_we, mem_re, mem_addr, mem_wdata, mem_dump,
           empty, count
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ready, mem_rdata, dump_req,
    input  cpu_rdata, stall, mem_we, mem_re, mem_addr, mem_wdata, mem_dump,
           empty, count
  );

endinterface

// File: rtl/dm_store_buffer_fifo.sv
// -----------------------------------------------------------------------------
// stbuf_fifo: storage, head/tail pointers and occupancy for the store buffer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry at tail on the clock edge
//   pop         : retire head entry on the clock edge (caller ensures !empty)
//   head_entry  : oldest entry
//   ent_age     : all entries in age order, [0] = oldest
//   ent_valid   : per-position valid flag matching ent_age
//   count/full/empty : occupancy
// -----------------------------------------------------------------------------
module stbuf_fifo
  import stbuf_pkg::*;
#(
  parameter int unsigned DEPTH = STBUF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  stbuf_entry_t                   push_entry,
  output stbuf_entry_t                   head_entry,
  output stbuf_entry_t [DEPTH-1:0]       ent_age,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  stbuf_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Rotate storage so position 0 is the oldest entry; pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    ent_age   = '0;
    ent_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_age[i]   = mem_q[head_q + PW'(i)];
      ent_valid[i] = (CW'(i) < count_q);
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer: posted-write buffer between the MEM stage and dmem.
// Stores are queued and retired in FIFO order whenever the memory port is
// free; loads go to memory (read port has priority over draining) or, with
// forwarding, are served from the youngest matching buffered store.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, discards all buffered stores
//   bus   : dm_store_buffer_if.slave (CPU request/response, memory strobes,
//           dump request/strobe, empty/count status)
// Optional feature macro: STBUF_FWD_EN (store-to-load forwarding). When
// undefined, loads are only legal with the buffer empty and no address
// comparators are built.
// -----------------------------------------------------------------------------
module dm_store_buffer
  import stbuf_pkg::*;
#(
  parameter int unsigned N     = STBUF_N,
  parameter int unsigned DEPTH = STBUF_DEPTH,
  parameter int unsigned AW    = STBUF_AW
) (
  input  logic             clk,
  input  logic             reset,
  dm_store_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  stbuf_entry_t             push_entry;
  stbuf_entry_t             head_entry;
  stbuf_entry_t [DEPTH-1:0] ent_age;
  logic [DEPTH-1:0]         ent_valid;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     empty;

  logic [AW-1:0] req_waddr;
  logic          fwd_hit;
  logic [N-1:0]  fwd_data;
  logic          read_legal;
  logic          mem_re;
  logic          drain;
  logic          push;
  logic          read_served;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[N-1:AW+3], bus.cpu_addr[2:0]};

  assign req_waddr  = bus.cpu_addr[AW+2:3];
  assign push_entry = '{waddr: req_waddr, data: bus.cpu_wdata};

  stbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .pop        (drain),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .ent_age    (ent_age),
    .ent_valid  (ent_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

`ifdef STBUF_FWD_EN
  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.cpu_re && ent_valid[i] && (ent_age[i].waddr == req_waddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_age[i].data;
      end
    end
  end
  assign read_legal = 1'b1;
`else
  logic unused_fwd_view;
  assign unused_fwd_view = ^{ent_age, ent_valid};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  // Without forwarding a load may only bypass an empty buffer.
  assign read_legal = empty;
`endif

  always_comb begin
    mem_re      = reset && bus.cpu_re && !fwd_hit && bus.mem_ready && read_legal;
    read_served = fwd_hit || mem_re;
    drain       = reset && !empty && bus.mem_ready && !mem_re;
    push        = reset && bus.cpu_we && (!full || drain);
  end

  always_comb begin
    bus.mem_re    = mem_re;
    bus.mem_we    = drain;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (mem_re) begin
      bus.mem_addr = req_waddr;
    end else if (drain) begin
      bus.mem_addr  = head_entry.waddr;
      bus.mem_wdata = head_entry.data;
    end
    bus.cpu_rdata = '0;
    if (fwd_hit) begin
      bus.cpu_rdata = fwd_data;
    end else if (mem_re) begin
      bus.cpu_rdata = bus.mem_rdata;
    end
    bus.stall    = reset && ((bus.cpu_we && full && !drain) ||
                             (bus.cpu_re && !read_served));
    bus.mem_dump = reset && bus.dump_req && empty && !bus.cpu_we;
    bus.empty    = empty;
    bus.count    = count;
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_store_buffer: directed, table-driven bench for dm_store_buffer.
// Each vector drives one cycle of inputs and lists the combinational outputs
// expected before the next rising edge. Sequences whose behaviour depends on
// STBUF_FWD_EN are written by hand for both builds.
// -----------------------------------------------------------------------------
module tb_dm_store_buffer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dm_store_buffer_if #(.N(64), .DEPTH(4), .AW(6)) bus ();

  dm_store_buffer #(.N(64), .DEPTH(4), .AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(bus.cpu_we && bus.cpu_re));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rdy;
    logic        dump;
    logic [63:0] mrd;
    logic        e_stall;
    logic        e_we;
    logic        e_re;
    logic        e_dump;
    logic [5:0]  e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    logic [2:0]  e_count;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mkv(
    input logic we, re, input logic [63:0] addr, wdata,
    input logic rdy, dump, input logic [63:0] mrd,
    input logic s, w, r, d, input logic [5:0] ma,
    input logic [63:0] mw, rd, input logic [2:0] c, input logic e);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.rdy = rdy; v.dump = dump; v.mrd = mrd;
    v.e_stall = s; v.e_we = w; v.e_re = r; v.e_dump = d;
    v.e_addr = ma; v.e_wdata = mw; v.e_rdata = rd; v.e_count = c; v.e_empty = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge, check before the next edge,
  // then advance to 1 time unit after that edge.
  task automatic apply(input string tag, input vec_t v);
    bus.cpu_we    = v.we;
    bus.cpu_re    = v.re;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.mem_ready = v.rdy;
    bus.dump_req  = v.dump;
    bus.mem_rdata = v.mrd;
    #3;
    chk({tag, ".stall"},    64'(bus.stall),    64'(v.e_stall));
    chk({tag, ".mem_we"},   64'(bus.mem_we),   64'(v.e_we));
    chk({tag, ".mem_re"},   64'(bus.mem_re),   64'(v.e_re));
    chk({tag, ".mem_dump"}, 64'(bus.mem_dump), 64'(v.e_dump));
    chk({tag, ".count"},    64'(bus.count),    64'(v.e_count));
    chk({tag, ".empty"},    64'(bus.empty),    64'(v.e_empty));
    if (v.e_we || v.e_re) chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(v.e_addr));
    if (v.e_we) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.e_wdata);
    if (v.re && !v.e_stall) chk({tag, ".cpu_rdata"}, bus.cpu_rdata, v.e_rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0; bus.dump_req = 1'b0; bus.mem_rdata = '0;
  endtask

  vec_t tab[25];

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();

    // Reset values with requests that would otherwise raise strobes.
    bus.mem_ready = 1'b1;
    bus.dump_req  = 1'b1;
    #2;
    chk("rst.count",    64'(bus.count),    64'd0);
    chk("rst.empty",    64'(bus.empty),    64'd1);
    chk("rst.mem_dump", 64'(bus.mem_dump), 64'd0);
    chk("rst.mem_we",   64'(bus.mem_we),   64'd0);
    bus.dump_req = 1'b0;
    bus.cpu_re   = 1'b1;
    bus.mem_rdata = 64'h55;
    #1;
    chk("rst.mem_re",    64'(bus.mem_re),  64'd0);
    chk("rst.stall",     64'(bus.stall),   64'd0);
    chk("rst.cpu_rdata", bus.cpu_rdata,    64'd0);
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    //          we re addr    wdata   rdy dmp mrd      s w r d  ma mw      rd       c e
    tab[0]  = mkv(1,0,'h10,  'hDEAD, 1,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[1]  = mkv(0,0,0,     0,      1,0,0,       0,1,0,0, 2,'hDEAD, 0,       1,0);
    tab[2]  = mkv(0,0,0,     0,      1,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[3]  = mkv(1,0,'h0,   'h100,  0,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[4]  = mkv(1,0,'h8,   'h101,  0,0,0,       0,0,0,0, 0,0,      0,       1,0);
    tab[5]  = mkv(1,0,'h10,  'h102,  0,0,0,       0,0,0,0, 0,0,      0,       2,0);
    tab[6]  = mkv(1,0,'h18,  'h103,  0,0,0,       0,0,0,0, 0,0,      0,       3,0);
    tab[7]  = mkv(1,0,'h20,  'h104,  0,0,0,       1,0,0,0, 0,0,      0,       4,0);
    tab[8]  = mkv(1,0,'h20,  'h104,  1,0,0,       0,1,0,0, 0,'h100,  0,       4,0);
    tab[9]  = mkv(0,0,0,     0,      1,0,0,       0,1,0,0, 1,'h101,  0,       4,0);
    tab[10] = mkv(0,0,0,     0,      1,0,0,       0,1,0,0, 2,'h102,  0,       3,0);
    tab[11] = mkv(0,0,0,     0,      1,0,0,       0,1,0,0, 3,'h103,  0,       2,0);
    tab[12] = mkv(0,0,0,     0,      1,0,0,       0,1,0,0, 4,'h104,  0,       1,0);
    tab[13] = mkv(0,0,0,     0,      1,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[14] = mkv(1,0,'h28,  'h200,  0,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[15] = mkv(1,0,'h30,  'h201,  0,0,0,       0,0,0,0, 0,0,      0,       1,0);
    tab[16] = mkv(0,0,0,     0,      1,1,0,       0,1,0,0, 5,'h200,  0,       2,0);
    tab[17] = mkv(0,0,0,     0,      1,1,0,       0,1,0,0, 6,'h201,  0,       1,0);
    tab[18] = mkv(0,0,0,     0,      1,1,0,       0,0,0,1, 0,0,      0,       0,1);
    tab[19] = mkv(0,0,0,     0,      1,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[20] = mkv(1,0,'h38,  'h300,  0,1,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[21] = mkv(0,0,0,     0,      1,1,0,       0,1,0,0, 7,'h300,  0,       1,0);
    tab[22] = mkv(0,0,0,     0,      1,0,0,       0,0,0,0, 0,0,      0,       0,1);
    tab[23] = mkv(0,1,'h48,  0,      1,0,'hBEEF,  0,0,1,0, 9,0,      'hBEEF,  0,1);
    tab[24] = mkv(0,1,'h48,  0,      0,0,'hBEEF,  1,0,0,0, 0,0,      0,       0,1);

    for (int i = 0; i < 25; i++) begin
      apply($sformatf("v%0d", i), tab[i]);
    end

    // Read priority over drain.
    apply("rp0", mkv(1,0,'h28,'h500,0,0,0,     0,0,0,0, 0,0,0,       0,1));
    apply("rp1", mkv(1,0,'h30,'h501,0,0,0,     0,0,0,0, 0,0,0,       1,0));
`ifdef STBUF_FWD_EN
    apply("rp2", mkv(0,1,'h40,0,1,0,'hCAFE,    0,0,1,0, 8,0,'hCAFE,  2,0));
    apply("rp3", mkv(0,0,0,0,1,0,0,            0,1,0,0, 5,'h500,0,   2,0));
    apply("rp4", mkv(0,0,0,0,1,0,0,            0,1,0,0, 6,'h501,0,   1,0));
`else
    apply("rp2", mkv(0,1,'h40,0,1,0,'hCAFE,    1,1,0,0, 5,'h500,0,   2,0));
    apply("rp3", mkv(0,1,'h40,0,1,0,'hCAFE,    1,1,0,0, 6,'h501,0,   1,0));
    apply("rp4", mkv(0,1,'h40,0,1,0,'hCAFE,    0,0,1,0, 8,0,'hCAFE,  0,1));
`endif
    apply("rp5", mkv(0,0,0,0,0,0,0,            0,0,0,0, 0,0,0,       0,1));

    // Forwarding (youngest store wins) / load blocked until drained.
    apply("fw0", mkv(1,0,'h18,'hA,0,0,0,       0,0,0,0, 0,0,0,       0,1));
    apply("fw1", mkv(1,0,'h18,'hB,0,0,0,       0,0,0,0, 0,0,0,       1,0));
`ifdef STBUF_FWD_EN
    apply("fw2", mkv(0,1,'h18,0,0,0,'h77,      0,0,0,0, 0,0,'hB,     2,0));
    apply("fw3", mkv(0,1,'h18,0,1,0,'h77,      0,1,0,0, 3,'hA,'hB,   2,0));
    apply("fw4", mkv(0,1,'h18,0,0,0,'h77,      0,0,0,0, 0,0,'hB,     1,0));
    apply("fw5", mkv(0,0,0,0,1,0,0,            0,1,0,0, 3,'hB,0,     1,0));
`else
    apply("fw2", mkv(0,1,'h18,0,0,0,'h77,      1,0,0,0, 0,0,0,       2,0));
    apply("fw3", mkv(0,1,'h18,0,1,0,'h77,      1,1,0,0, 3,'hA,0,     2,0));
    apply("fw4", mkv(0,1,'h18,0,1,0,'h77,      1,1,0,0, 3,'hB,0,     1,0));
    apply("fw5", mkv(0,1,'h18,0,1,0,'h77,      0,0,1,0, 3,0,'h77,    0,1));
`endif
    apply("fw6", mkv(0,0,0,0,0,0,0,            0,0,0,0, 0,0,0,       0,1));

    // Reset mid-operation with three stores held.
    apply("rm0", mkv(1,0,'h0,'h11,0,0,0,       0,0,0,0, 0,0,0,       0,1));
    apply("rm1", mkv(1,0,'h8,'h12,0,0,0,       0,0,0,0, 0,0,0,       1,0));
    apply("rm2", mkv(1,0,'h10,'h13,0,0,0,      0,0,0,0, 0,0,0,       2,0));
    idle_inputs();
    bus.mem_ready = 1'b1;
    #1;
    chk("rm.pre_count", 64'(bus.count),  64'd3);
    chk("rm.pre_we",    64'(bus.mem_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("rm.count",  64'(bus.count),  64'd0);
    chk("rm.empty",  64'(bus.empty),  64'd1);
    chk("rm.mem_we", 64'(bus.mem_we), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("rm.post%0d.mem_we", k), 64'(bus.mem_we), 64'd0);
      chk($sformatf("rm.post%0d.count", k),  64'(bus.count),  64'd0);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Posted-write buffer between the pipelined processor's data-memory port (DM_addr, DM_writeData, DM_writeEnable, DM_readEnable, DM_readData) and `dmem`. Stores from the MEM stage are captured into a small FIFO and retired to memory in later cycles whenever the memory port is free. Loads are served from memory, or forwarded from the buffer when enabled. The block raises `stall` when it cannot accept the current access, which the pipeline's hazard logic ORs into its MEM-stage stall.

## Interface
- `N`, 64: data width.
- `DEPTH`, 4: store entries; power of two, ≥2.
- `AW`, 6: memory word-address width; word address = `cpu_addr[AW+2:3]`.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `cpu_addr`  in  N  byte address from the datapath.
- `cpu_wdata`  in  N  store data.
- `cpu_we`  in  1  store request.
- `cpu_re`  in  1  load request; `cpu_we && cpu_re` in one cycle is illegal (bench asserts).
- `cpu_rdata`  out  N  load data, combinational.
- `stall`  out  1  current request not accepted; the CPU holds it.
- `mem_ready`  in  1  memory port may be used this cycle.
- `mem_we`, `mem_re`  out  1  memory strobes.
- `mem_addr`  out  AW  memory word address.
- `mem_wdata`  out  N  memory write data.
- `mem_rdata`  in  N  memory read data, combinational.
- `dump_req`  in  1  dump request from the testbench.
- `mem_dump`  out  1  dump strobe to `dmem`.
- `empty`  out  1  no entries held.
- `count`  out  $clog2(DEPTH+1)  entries held.

## Operation
- Each entry holds {word address, data}. Head and tail pointers wrap modulo DEPTH. `full` = (count == DEPTH).
- Read service:
  - If forwarding hits, data comes from the buffer.
  - Otherwise, if `cpu_re && mem_ready` and the read is legal (see Configuration), the block drives `mem_re=1`, `mem_addr` = load word address, and `cpu_rdata = mem_rdata`.
- Drain: `drain = !empty && mem_ready && !mem_re`. On drain, the block drives `mem_we=1`, `mem_addr`/`mem_wdata` from the head entry, and pops the head at the clock edge. The read port always has priority over drain.
- Push: `cpu_we && (!full || drain)` pushes at the clock edge. A push and a pop in the same cycle leave `count` unchanged.
- `stall = (cpu_we && full && !drain) || (cpu_re && !read_served)`.
- Dump: `mem_dump = dump_req && empty && !cpu_we`. While `dump_req` is high, draining continues normally.
- While `reset` is low, `mem_we`, `mem_re`, `mem_dump` and `stall` are forced to 0.

## Timing
- Reset values: `count=0`, `empty=1`, pointers 0, all strobes 0, `cpu_rdata=0`.
- Load latency is 0 cycles; the load path is combinational.
- A store accepted at edge t can drain no earlier than the cycle after t. There is no same-cycle bypass of the CPU's store to memory.
- Drain order is strictly FIFO. At most one memory access occurs per cycle.
- Reset asserted mid-operation discards all buffered stores.

## Configuration
- `STBUF_FWD_EN` defined:
  - A load compares its word address against all valid entries, youngest first.
  - On a hit, `cpu_rdata` = that entry's data, `mem_re=0`, no stall, and drain proceeds in the same cycle.
  - On a miss, the load goes to memory; entries at other addresses may remain buffered.
- `STBUF_FWD_EN` undefined:
  - A load is legal only when `empty`. Otherwise `stall=1` and the buffer drains until empty.
  - No address comparators are built.

## Structure
- Package `stbuf_pkg` holds the `stbuf_entry_t` struct {word address, data} and the default DEPTH/AW constants.
- Sub-module `stbuf_fifo` holds storage, pointers, count, and full/empty logic, and exposes a read-all-entries view for the forwarding search.
- The top level holds arbitration, stall, forwarding, and dump logic.

## Test plan
- Basic store: after reset, store to 0x10 with data 0xDEAD while `mem_ready=1`. Next cycle: `count=1`, `mem_we=1`, `mem_addr=2`, `mem_wdata=0xDEAD`. The cycle after: `empty=1`.
- Full: with `mem_ready=0`, stores to 0x0, 0x8, 0x10, 0x18 are accepted. A fifth store to 0x20 gives `stall=1`. Raising `mem_ready` in that cycle gives `stall=0` and a push plus a pop. Drains then occur in address order 0,1,2,3,4.
- Forwarding: with `mem_ready=0`, store 0x18←0xA, then store 0x18←0xB, then load 0x18. With the macro: `cpu_rdata=0xB`, `stall=0`, `mem_re=0`. Without the macro: `stall=1` until `mem_ready=1` and the buffer has drained 2 entries, after which `mem_re=1`.
- Read priority: with 2 entries held, `mem_ready=1`, a load to 0x40 (miss) gives `mem_re=1` and no `mem_we` that cycle; `count` stays 2.
- Dump: `dump_req=1` with 2 entries held and `mem_ready=1` gives `mem_dump=0` for 2 cycles, then 1.
- Reset mid-operation: with 3 entries held, drop `reset`. `count=0` and `mem_we=0` take effect immediately, before the next edge. No buffered stores reach memory afterwards.
